// File: rtl/thread_fetch_sched_if.sv
// Fetch-scheduler bus: control, decoder feedback and branch redirects in; fetch stream and status out.
interface thread_fetch_sched_if #(
  parameter int INST_ADDR_WIDTH = 9,
  parameter int THREAD_BITS     = 2,
  parameter int NUM_THREADS     = 4
);
  logic                       start;
  logic                       stall;
  logic [NUM_THREADS-1:0]     thread_done_in;
  logic                       branch_taken_in;
  logic [THREAD_BITS-1:0]     branch_thread_in;
  logic [INST_ADDR_WIDTH-1:0] branch_pc_in;
  logic [INST_ADDR_WIDTH-1:0] branch_offset_in;
  logic [INST_ADDR_WIDTH-1:0] inst_addr_out;
  logic [THREAD_BITS-1:0]     thread_id_out;
  logic                       fetch_valid;
  logic [NUM_THREADS-1:0]     done_mask;
  logic                       all_done;
  logic [31:0]                run_cycles;

  // Scheduler side
  modport master (
    input  start, stall, thread_done_in, branch_taken_in, branch_thread_in,
           branch_pc_in, branch_offset_in,
    output inst_addr_out, thread_id_out, fetch_valid, done_mask, all_done, run_cycles
  );

  // Core/environment side
  modport slave (
    output start, stall, thread_done_in, branch_taken_in, branch_thread_in,
           branch_pc_in, branch_offset_in,
    input  inst_addr_out, thread_id_out, fetch_valid, done_mask, all_done, run_cycles
  );
endinterface

// File: rtl/thread_fetch_sched.sv
// Round-robin fetch scheduler for the 4-thread fine-grained core: per-thread PCs,
// branch redirects, sticky halt mask and IDLE/RUN/DONE sequencing.
module thread_fetch_sched #(
  parameter int INST_ADDR_WIDTH = 9,
  parameter int THREAD_BITS     = 2,
  parameter int NUM_THREADS     = 4
) (
  input logic                  clk,
  input logic                  reset,
  thread_fetch_sched_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                     state, state_nxt;
  logic [INST_ADDR_WIDTH-1:0] pc [NUM_THREADS];
  logic [THREAD_BITS-1:0]     rr_ptr, sel, cand;
  logic                       found, in_run, issue, restart, br_ok;
  logic [NUM_THREADS-1:0]     done_eff;
  logic [INST_ADDR_WIDTH-1:0] br_target;

  assign in_run    = (state == RUN);
  assign done_eff  = bus.done_mask | bus.thread_done_in;
  assign issue     = in_run && !bus.stall && found;
  assign restart   = bus.start && (state != RUN);
  // A same-cycle halt pulse for the branch's thread also kills the redirect
  assign br_ok     = in_run && bus.branch_taken_in && !done_eff[bus.branch_thread_in];
  assign br_target = bus.branch_pc_in + bus.branch_offset_in;

  // Walk from farthest to nearest so the first live thread after rr_ptr wins
  always_comb begin
    sel   = rr_ptr;
    found = 1'b0;
    cand  = '0;
    for (int k = NUM_THREADS; k >= 1; k--) begin
      cand = rr_ptr + THREAD_BITS'(k);
      if (!done_eff[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (&done_eff) state_nxt = DONE;
      DONE:    if (bus.start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.inst_addr_out <= '0;
      bus.thread_id_out <= '0;
      bus.fetch_valid   <= 1'b0;
      bus.done_mask     <= '0;
      bus.all_done      <= 1'b0;
      bus.run_cycles    <= '0;
      rr_ptr            <= THREAD_BITS'(NUM_THREADS-1);
    end else begin
      bus.all_done <= (state_nxt == DONE);
      if (restart) begin
        bus.fetch_valid <= 1'b0;
        bus.done_mask   <= '0;
        bus.run_cycles  <= '0;
        rr_ptr          <= THREAD_BITS'(NUM_THREADS-1);
      end else if (in_run) begin
        bus.run_cycles  <= bus.run_cycles + 32'd1;
        bus.done_mask   <= done_eff;
        bus.fetch_valid <= issue;
        if (issue) begin
          bus.inst_addr_out <= pc[sel];
          bus.thread_id_out <= sel;
          rr_ptr            <= sel;
        end
      end else begin
        bus.fetch_valid <= 1'b0;
      end
    end
  end

  // Redirect beats the post-issue increment; the old PC has already been fetched
  always_ff @(posedge clk) begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (reset || restart)
        pc[t] <= INST_ADDR_WIDTH'(t) << (INST_ADDR_WIDTH - THREAD_BITS);
      else if (br_ok && bus.branch_thread_in == THREAD_BITS'(t))
        pc[t] <= br_target;
      else if (issue && sel == THREAD_BITS'(t))
        pc[t] <= pc[t] + INST_ADDR_WIDTH'(1);
    end
  end
endmodule
